alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the lab ALU. It registers the operands under a valid/ready handshake and executes logic and add/sub operations in one cycle. Shifts run iteratively, one bit per cycle, with a fill bit taken from `ALUFlagIn`; an optional shift-add multiplier also runs iteratively. It sits between the register-file read stage and the write-back stage of the lab datapath, and it can stall both sides.

## Interface
- `N`, default 4: operand and result width, minimum 2.
- `clk`  in  1: single clock; everything is sampled on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ALUA`  in  N: operand A.
- `ALUB`  in  N: operand B. For shifts, B is the shift amount.
- `ALUControl`  in  4: opcode.
- `ALUFlagIn`  in  1: fill bit for shifts.
- `in_valid`  in  1: operands and opcode are valid.
- `in_ready`  out  1: the block accepts a request this cycle.
- `ALUResult`  out  N: result, or the low half of the product.
- `ALUResultHi`  out  N: high half of the product. Present only with `ALU_SEQ_MUL_EN`.
- `C`  out  1: carry / borrow-free / last shifted-out bit / high half nonzero, depending on the opcode.
- `Z`  out  1: result zero.
- `out_valid`  out  1: result and flags are valid.
- `out_ready`  in  1: the consumer takes the result.

## Operation
- A request is accepted when `in_valid && in_ready`. A, B, opcode and FlagIn are all registered at the accept edge.
- Opcodes:
  - 0 AND, 1 OR, 7 XOR: C=0.
  - 2 ADD: C = carry out.
  - 6 SUB (A−B): C=1 when A≥B, unsigned.
  - 3 INC (A+1) and 4 DEC (A−1): C is the carry/borrow-free bit as for ADD/SUB.
  - 5 NOT A: C=0.
  - 8 SHL: shift left by B, filling LSBs with FlagIn.
  - 9 SHR: shift right by B, filling MSBs with FlagIn.
  - A MUL: unsigned product, 2N bits.
  - Any other code: ALUResult=0, C=0, Z=1, latency 1.
- Shift count S = min(B, N). Each step moves one bit, and C = the bit leaving on the last step.
- S=0: result=A, C=0.
- S=N: result is all FlagIn; C=A[0] for SHL, C=A[N−1] for SHR.
- MUL: one shift-add step per cycle for N cycles. C = (ALUResultHi != 0); Z = whole 2N-bit product == 0.
- Without MUL, opcode A is treated as illegal.
- Z = (ALUResult == 0) for every non-MUL opcode.
- FSM states:
  - IDLE: `in_ready`=1. Accepting a single-cycle op, S=0 shift or illegal code → DONE. Accepting a shift with S≥1 or MUL → EXEC.
  - EXEC: one step per cycle. On the final step → DONE.
  - DONE: `out_valid`=1; outputs are held stable until `out_ready`. On `out_ready`:
    - with `in_valid` → accept the next request in the same cycle (next state per the IDLE rules);
    - without `in_valid` → IDLE.
- `in_ready` = IDLE || (DONE && out_ready). `in_ready` is 0 throughout EXEC.

## Timing
- Reset: state=IDLE; ALUResult, ALUResultHi, C, Z, out_valid all 0; in_ready=1 from the first cycle after reset.
- Reset while in EXEC or DONE aborts the operation and discards the result; no out_valid pulse follows.
- Latency from accept edge to first out_valid cycle:
  - 1 cycle for logic/arith ops, S=0 shifts and illegal codes;
  - 1+S for shifts;
  - 1+N for MUL.
- Throughput with `out_ready` held at 1: one single-cycle op per clock (back-to-back through DONE).
- Inputs are not sampled outside the accept edge. Changing A/B during EXEC has no effect.
- `out_ready` with `out_valid`=0 is ignored.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL opcode, `ALUResultHi` port, product register and multiplier datapath are present.
- Not defined: all of that is removed, the `ALUResultHi` port does not exist, and opcode A behaves as illegal (result 0, Z=1, latency 1).

## Structure
- `alu_seq_pkg` holds:
  - opcode localparams (OP_AND … OP_MUL);
  - the FSM state typedef (IDLE, EXEC, DONE);
  - a helper function for the shift-count width, $clog2(N+1).
- One sub-module, `alu_seq_iter`, holds the iterative shifter/multiplier: step counter, working registers and last-out bit.
- The top level holds the single-cycle combinational unit, the FSM, the handshake logic and the output registers.

## Test plan
- N=4, SHL, A=0110 B=0010 FlagIn=0 → ALUResult=1000, C=1, Z=0, out_valid 3 cycles after accept; repeat with FlagIn=1 → 1011, C=1.
- SHR, A=0110 B=0010 FlagIn=1 → 1101, C=1. Then B=0000 → 0110, C=0, latency 1. Then B=1111 FlagIn=0 → 0000, Z=1, C=0, latency 5.
- ADD 1101+1011 → 1000, C=1. SUB 0010−0011 → 1111, C=0. SUB 0101−0101 → 0000, Z=1, C=1.
- Hold `out_ready`=0 for 4 cycles after a result: ALUResult, flags and out_valid stay stable and in_ready=0. Then `out_ready`=1 with a new `in_valid` → accepted the same cycle; 8 back-to-back ADDs complete at 1 per clock.
- With `ALU_SEQ_MUL_EN`: 1101×1011 → Hi=1000, Result=1111, C=1, latency 5. 0000×1011 → Z=1. Without the macro, opcode A → 0000, Z=1.
- Assert `rst` on the 2nd EXEC cycle of a 4-bit shift → next cycle IDLE, all outputs 0, in_ready=1, and no stale out_valid afterwards.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the sequential ALU.
// The optional multiplier is controlled by the ALU_SEQ_MUL_EN macro in the other files.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_INC = 4'h3;
    localparam logic [3:0] OP_DEC = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t DONE = 2'd2;

    // Step counter must hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine: one-bit-per-cycle shifter and, with ALU_SEQ_MUL_EN, a shift-add multiplier.
// Outputs are the values the working registers take on the current step, so the caller can latch them on the final step.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int N = 4,
    localparam int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          left,
    input  logic          fill,
`ifdef ALU_SEQ_MUL_EN
    input  logic          mul,
    input  logic [N-1:0]  b,
`endif
    input  logic [N-1:0]  a,
    input  logic [CW-1:0] count,
    output logic          last,
    output logic [N-1:0]  res_lo,
`ifdef ALU_SEQ_MUL_EN
    output logic [N-1:0]  res_hi,
`endif
    output logic          res_c,
    output logic          res_z
);

    logic [CW-1:0] cnt;
    logic [N-1:0]  lo;
    logic [N-1:0]  nxt_lo;
    logic          nxt_out;
    logic          is_left;
    logic          fill_r;
`ifdef ALU_SEQ_MUL_EN
    logic [N-1:0]  hi;
    logic [N-1:0]  mcand;
    logic [N-1:0]  nxt_hi;
    logic [N:0]    sum;
    logic          is_mul;
`endif

    // Multiply keeps the multiplier in lo and shifts the partial sum down into it.
    always_comb begin
        nxt_lo  = lo;
        nxt_out = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        nxt_hi  = hi;
        sum     = '0;
        if (is_mul) begin
            sum    = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {1'b0, hi};
            nxt_hi = sum[N:1];
            nxt_lo = {sum[0], lo[N-1:1]};
        end else
`endif
        if (is_left) begin
            nxt_lo  = {lo[N-2:0], fill_r};
            nxt_out = lo[N-1];
        end else begin
            nxt_lo  = {fill_r, lo[N-1:1]};
            nxt_out = lo[0];
        end
    end

    always_comb begin
        last   = (cnt == CW'(1));
        res_lo = nxt_lo;
`ifdef ALU_SEQ_MUL_EN
        res_hi = nxt_hi;
        res_c  = is_mul ? (|nxt_hi) : nxt_out;
        res_z  = is_mul ? ~(|{nxt_hi, nxt_lo}) : ~(|nxt_lo);
`else
        res_c  = nxt_out;
        res_z  = ~(|nxt_lo);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            lo      <= '0;
            is_left <= 1'b0;
            fill_r  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi      <= '0;
            mcand   <= '0;
            is_mul  <= 1'b0;
`endif
        end else if (start) begin
            cnt     <= count;
            is_left <= left;
            fill_r  <= fill;
`ifdef ALU_SEQ_MUL_EN
            lo      <= mul ? b : a;
            hi      <= '0;
            mcand   <= a;
            is_mul  <= mul;
`else
            lo      <= a;
`endif
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            lo  <= nxt_lo;
`ifdef ALU_SEQ_MUL_EN
            hi  <= nxt_hi;
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake on both sides; single-cycle ops finish in one clock.
// Define ALU_SEQ_MUL_EN to add the iterative multiplier and the ALUResultHi port.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] ALUA,
    input  logic [N-1:0] ALUB,
    input  logic [3:0]   ALUControl,
    input  logic         ALUFlagIn,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] ALUResult,
`ifdef ALU_SEQ_MUL_EN
    output logic [N-1:0] ALUResultHi,
`endif
    output logic         C,
    output logic         Z,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int CW = cnt_width(N);

    state_t        state;
    logic          accept;
    logic          is_shift;
    logic          is_mul;
    logic          iter_go;
    logic [CW-1:0] count;
    logic [N-1:0]  single_res;
    logic          single_c;
    logic [N:0]    wide;
    logic          it_last;
    logic [N-1:0]  it_lo;
    logic          it_c;
    logic          it_z;
`ifdef ALU_SEQ_MUL_EN
    logic [N-1:0]  it_hi;
`endif

    // Zero-length shifts also land here: result is A with C cleared.
    always_comb begin
        single_res = '0;
        single_c   = 1'b0;
        wide       = '0;
        case (ALUControl)
            OP_AND: single_res = ALUA & ALUB;
            OP_OR:  single_res = ALUA | ALUB;
            OP_XOR: single_res = ALUA ^ ALUB;
            OP_NOT: single_res = ~ALUA;
            OP_ADD: begin
                wide       = {1'b0, ALUA} + {1'b0, ALUB};
                single_res = wide[N-1:0];
                single_c   = wide[N];
            end
            OP_INC: begin
                wide       = {1'b0, ALUA} + (N+1)'(1);
                single_res = wide[N-1:0];
                single_c   = wide[N];
            end
            OP_DEC: begin
                wide       = {1'b0, ALUA} - (N+1)'(1);
                single_res = wide[N-1:0];
                single_c   = ~wide[N];
            end
            OP_SUB: begin
                wide       = {1'b0, ALUA} - {1'b0, ALUB};
                single_res = wide[N-1:0];
                single_c   = ~wide[N];
            end
            OP_SHL, OP_SHR: single_res = ALUA;
            default: ;
        endcase
    end

    always_comb begin
        is_shift = (ALUControl == OP_SHL) || (ALUControl == OP_SHR);
`ifdef ALU_SEQ_MUL_EN
        is_mul   = (ALUControl == OP_MUL);
`else
        is_mul   = 1'b0;
`endif
        iter_go  = (is_shift && (ALUB != '0)) || is_mul;
        if (is_mul || (ALUB >= N'(N)))
            count = CW'(N);
        else
            count = ALUB[CW-1:0];
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    alu_seq_iter #(.N(N)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && iter_go),
        .left   (ALUControl == OP_SHL),
        .fill   (ALUFlagIn),
`ifdef ALU_SEQ_MUL_EN
        .mul    (is_mul),
        .b      (ALUB),
`endif
        .a      (ALUA),
        .count  (count),
        .last   (it_last),
        .res_lo (it_lo),
`ifdef ALU_SEQ_MUL_EN
        .res_hi (it_hi),
`endif
        .res_c  (it_c),
        .res_z  (it_z)
    );

    // An accept in DONE takes priority over draining to IDLE so back-to-back ops never bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ALUResult   <= '0;
            C           <= 1'b0;
            Z           <= 1'b0;
            out_valid   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            ALUResultHi <= '0;
`endif
        end else if (accept) begin
            if (iter_go) begin
                state     <= EXEC;
                out_valid <= 1'b0;
            end else begin
                state       <= DONE;
                out_valid   <= 1'b1;
                ALUResult   <= single_res;
                C           <= single_c;
                Z           <= (single_res == '0);
`ifdef ALU_SEQ_MUL_EN
                ALUResultHi <= '0;
`endif
            end
        end else begin
            case (state)
                EXEC: if (it_last) begin
                    state       <= DONE;
                    out_valid   <= 1'b1;
                    ALUResult   <= it_lo;
                    C           <= it_c;
                    Z           <= it_z;
`ifdef ALU_SEQ_MUL_EN
                    ALUResultHi <= it_hi;
`endif
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                IDLE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, random ops against a behavioural model, stall and reset scenarios.
// Builds with or without ALU_SEQ_MUL_EN.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] ALUA;
    logic [N-1:0] ALUB;
    logic [3:0]   ALUControl;
    logic         ALUFlagIn;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] ALUResult;
`ifdef ALU_SEQ_MUL_EN
    logic [N-1:0] ALUResultHi;
`endif
    logic         C;
    logic         Z;
    logic         out_valid;
    logic         out_ready;

    int errors = 0;
    int checks = 0;

    alu_seq #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .ALUA        (ALUA),
        .ALUB        (ALUB),
        .ALUControl  (ALUControl),
        .ALUFlagIn   (ALUFlagIn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUResult   (ALUResult),
`ifdef ALU_SEQ_MUL_EN
        .ALUResultHi (ALUResultHi),
`endif
        .C           (C),
        .Z           (Z),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result straight from the opcode rules, using plain integer arithmetic.
    function automatic void model(input int op, input int a, input int b, input int fill,
                                  output int res, output int hi, output int c, output int z,
                                  output int lat);
        int s;
        int p;
        res = 0; hi = 0; c = 0; lat = 1; p = 0;
        case (op)
            0: res = a & b;
            1: res = a | b;
            7: res = a ^ b;
            5: res = ~a & MASK;
            2: begin res = (a + b) & MASK; c = int'(a + b > MASK); end
            3: begin res = (a + 1) & MASK; c = int'(a + 1 > MASK); end
            4: begin res = (a - 1) & MASK; c = int'(a >= 1); end
            6: begin res = (a - b) & MASK; c = int'(a >= b); end
            8, 9: begin
                s   = (b < N) ? b : N;
                lat = 1 + s;
                if (s == 0) res = a;
                else if (s == N) begin
                    res = fill ? MASK : 0;
                    c   = (op == 8) ? (a & 1) : ((a >> (N - 1)) & 1);
                end else if (op == 8) begin
                    res = ((a << s) | (fill ? ((1 << s) - 1) : 0)) & MASK;
                    c   = (a >> (N - s)) & 1;
                end else begin
                    res = (a >> s) | (fill ? (MASK & ~(MASK >> s)) : 0);
                    c   = (a >> (s - 1)) & 1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            10: begin
                p   = a * b;
                res = p & MASK;
                hi  = p >> N;
                c   = int'(hi != 0);
                lat = 1 + N;
            end
`endif
            default: ;
        endcase
        z = int'(res == 0 && hi == 0);
    endfunction

    // Issue one request from IDLE and wait (bounded) for out_valid; lat counts edges from accept.
    task automatic applyStimulus(input int op, input int a, input int b, input int fill, output int lat);
        @(negedge clk);
        checkOutput("in_ready_idle", 64'(in_ready), 64'(1));
        ALUControl = op[3:0];
        ALUA       = a[N-1:0];
        ALUB       = b[N-1:0];
        ALUFlagIn  = fill[0];
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ALUA     = N'($urandom_range(0, MASK));
        ALUB     = N'($urandom_range(0, MASK));
        lat = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic doOp(input string tag, input int op, input int a, input int b, input int fill);
        int er, eh, ec, ez, el, lat;
        model(op, a, b, fill, er, eh, ec, ez, el);
        applyStimulus(op, a, b, fill, lat);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(el));
        checkOutput({tag, "_res"}, 64'(ALUResult), 64'(er));
        checkOutput({tag, "_c"}, 64'(C), 64'(ec));
        checkOutput({tag, "_z"}, 64'(Z), 64'(ez));
`ifdef ALU_SEQ_MUL_EN
        checkOutput({tag, "_hi"}, 64'(ALUResultHi), 64'(eh));
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int er, eh, ec, ez, el, lat, saw;
        int ra, rb, rop;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALUA = '0; ALUB = '0; ALUControl = '0; ALUFlagIn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_res", 64'(ALUResult), 64'(0));
        checkOutput("rst_cz", 64'({C, Z}), 64'(0));
        checkOutput("rst_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_ready", 64'(in_ready), 64'(1));

        doOp("shl_f0", 8, 4'b0110, 4'b0010, 0);
        doOp("shl_f1", 8, 4'b0110, 4'b0010, 1);
        doOp("shr_f1", 9, 4'b0110, 4'b0010, 1);
        doOp("shr_s0", 9, 4'b0110, 4'b0000, 1);
        doOp("shr_big", 9, 4'b0110, 4'b1111, 0);
        doOp("shl_full", 8, 4'b1011, 4'b0100, 1);
        doOp("add_c", 2, 4'b1101, 4'b1011, 0);
        doOp("sub_brw", 6, 4'b0010, 4'b0011, 0);
        doOp("sub_eq", 6, 4'b0101, 4'b0101, 0);
        doOp("inc_wrap", 3, 4'b1111, 0, 0);
        doOp("dec_zero", 4, 4'b0000, 0, 0);
        doOp("not", 5, 4'b1010, 0, 0);
        doOp("xor", 7, 4'b1100, 4'b1010, 0);
        doOp("mul_a", 10, 4'b1101, 4'b1011, 0);
        doOp("mul_zero", 10, 4'b0000, 4'b1011, 0);
        doOp("illegal", 15, 4'b1111, 4'b1111, 1);

        for (int i = 0; i < 40; i++) begin
            rop = $urandom_range(0, 15);
            ra  = $urandom_range(0, MASK);
            rb  = $urandom_range(0, MASK);
            doOp("rand", rop, ra, rb, $urandom_range(0, 1));
        end

        // Stall: result must hold while out_ready stays low.
        model(2, 5, 6, 0, er, eh, ec, ez, el);
        applyStimulus(2, 5, 6, 0, lat);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_valid", 64'(out_valid), 64'(1));
            checkOutput("stall_res", 64'(ALUResult), 64'(er));
            checkOutput("stall_cz", 64'({C, Z}), 64'({ec[0], ez[0]}));
            checkOutput("stall_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end

        // Back-to-back adds through DONE, one per clock.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom_range(0, MASK);
            rb = $urandom_range(0, MASK);
            ALUControl = OP_ADD;
            ALUA = ra[N-1:0];
            ALUB = rb[N-1:0];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            checkOutput("b2b_ready", 64'(in_ready), 64'(1));
            model(2, ra, rb, 0, er, eh, ec, ez, el);
            @(negedge clk);
            checkOutput("b2b_valid", 64'(out_valid), 64'(1));
            checkOutput("b2b_res", 64'(ALUResult), 64'(er));
            checkOutput("b2b_c", 64'(C), 64'(ec));
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_drain", 64'(out_valid), 64'(0));
        out_ready = 1'b0;

        // Reset on the second EXEC cycle of a 4-step shift.
        @(negedge clk);
        ALUControl = OP_SHL; ALUA = 4'b1011; ALUB = 4'b0100; ALUFlagIn = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_res", 64'(ALUResult), 64'(0));
        checkOutput("abort_cz", 64'({C, Z}), 64'(0));
        checkOutput("abort_valid", 64'(out_valid), 64'(0));
        checkOutput("abort_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;
        out_ready = 1'b1;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw++;
        end
        checkOutput("abort_stale", 64'(saw), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
